// File: rtl/decode_pkg.sv
// Shared types for the decode stage: opcode set, default field widths, decoded entry layout.
package decode_pkg;

    localparam int unsigned OFF_W_DEF = 13;
    localparam int unsigned REG_W_DEF = 5;
    localparam int unsigned OP_W_DEF  = 4;
    localparam int unsigned CNT_W_DEF = 16;

    // LAST_OP is the count of legal opcodes, not an opcode itself
    typedef enum logic [OP_W_DEF-1:0] {
        ADD, SUB, AND, OR, XOR, SHL, SHR, LW,
        SW, BEQ, BGT, BGE, JMP,
        LAST_OP
    } opcode_e;

    typedef struct packed {
        logic [OFF_W_DEF-1:0] offset;
        logic [REG_W_DEF-1:0] ra;
        logic [REG_W_DEF-1:0] rb;
        logic [REG_W_DEF-1:0] rd;
        logic [OP_W_DEF-1:0]  opcode;
        logic                 exc;
    } dec_entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_TWO
    } buf_state_e;

endpackage

// File: rtl/decode_skid.sv
// Two-entry FIFO skid buffer with registered ready/valid; head entry drives the outputs.
module decode_skid
    import decode_pkg::*;
#(
    parameter type T = dec_entry_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  T     in_data_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    output T     out_data_o,
    output logic out_valid_o,
    input  logic out_ready_i
);

    buf_state_e state_q, state_d;
    T           head_q, skid_q;
    logic       ready_q, valid_q;
    logic       in_xfer, out_xfer;
    logic       head_ld, head_from_skid, skid_ld;

    assign in_xfer  = in_valid_i & ready_q;
    assign out_xfer = valid_q & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy transitions; flush wins over any transfer
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: if (in_xfer) state_d = BUF_ONE;
                BUF_ONE: begin
                    if (in_xfer && !out_xfer)      state_d = BUF_TWO;
                    else if (!in_xfer && out_xfer) state_d = BUF_EMPTY;
                end
                BUF_TWO:   if (out_xfer) state_d = BUF_ONE;
                default:   state_d = BUF_EMPTY;
            endcase
        end
    end

    always_comb begin
        head_ld        = 1'b0;
        head_from_skid = 1'b0;
        skid_ld        = 1'b0;
        if (!flush_i) begin
            case (state_q)
                BUF_EMPTY: head_ld = in_xfer;
                BUF_ONE: begin
                    head_ld = in_xfer & out_xfer;
                    skid_ld = in_xfer & ~out_xfer;
                end
                BUF_TWO: begin
                    head_ld        = out_xfer;
                    head_from_skid = out_xfer;
                end
                default: ;
            endcase
        end
    end

    // Data holds on flush so the field outputs keep their last values
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (head_ld) head_q <= head_from_skid ? skid_q : in_data_i;
            if (skid_ld) skid_q <= in_data_i;
            ready_q <= (state_d != BUF_TWO);
            valid_q <= (state_d != BUF_EMPTY);
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = head_q;

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: field slicing and malformed-instruction detection in front of a skid buffer.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned OFF_W   = OFF_W_DEF,
    parameter int unsigned REG_W   = REG_W_DEF,
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned NUM_OPS = 32'(LAST_OP),
    parameter int unsigned CNT_W   = CNT_W_DEF,
    localparam int unsigned ILEN   = OFF_W + 3*REG_W + OP_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic [ILEN-1:0]   instr_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    output logic [OFF_W-1:0]  offset_o,
    output logic [REG_W-1:0]  ra_o,
    output logic [REG_W-1:0]  rb_o,
    output logic [REG_W-1:0]  rd_o,
    output logic [OP_W-1:0]   opcode_o,
    output logic              exception_o,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [CNT_W-1:0]  exc_count_o
);

    typedef struct packed {
        logic [OFF_W-1:0] offset;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [REG_W-1:0] rd;
        logic [OP_W-1:0]  opcode;
        logic             exc;
    } entry_t;

    entry_t           in_entry, out_entry;
    logic             illegal_op, rd_forbidden;
    logic [CNT_W-1:0] exc_count_q;

    // Slice at acceptance; stores and control transfers must not name a destination
    always_comb begin
        in_entry        = '0;
        in_entry.opcode = instr_i[OP_W-1:0];
        in_entry.rd     = instr_i[OP_W +: REG_W];
        in_entry.rb     = instr_i[OP_W+REG_W +: REG_W];
        in_entry.ra     = instr_i[OP_W+2*REG_W +: REG_W];
        in_entry.offset = instr_i[OP_W+3*REG_W +: OFF_W];
        illegal_op      = (32'(in_entry.opcode) >= NUM_OPS);
        rd_forbidden    = in_entry.opcode inside {OP_W'(SW), OP_W'(BEQ), OP_W'(BGT),
                                                  OP_W'(BGE), OP_W'(JMP)};
        in_entry.exc    = illegal_op | (rd_forbidden & (in_entry.rd != '0));
    end

    decode_skid #(
        .T (entry_t)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_data_i   (in_entry),
        .in_valid_i  (instr_valid_i),
        .in_ready_o  (instr_ready_o),
        .out_data_o  (out_entry),
        .out_valid_o (dec_valid_o),
        .out_ready_i (dec_ready_i)
    );

    assign offset_o    = out_entry.offset;
    assign ra_o        = out_entry.ra;
    assign rb_o        = out_entry.rb;
    assign rd_o        = out_entry.rd;
    assign opcode_o    = out_entry.opcode;
    assign exception_o = dec_valid_o & out_entry.exc;

    // Saturating count of exceptions actually handed downstream
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exc_count_q <= '0;
        end else if (dec_valid_o && dec_ready_i && !flush_i && out_entry.exc
                     && (exc_count_q != '1)) begin
            exc_count_q <= exc_count_q + CNT_W'(1);
        end
    end

    assign exc_count_o = exc_count_q;

endmodule
